wb_regfile_dual: RTL

- Writeback-side consumer of the dual-slot MEM/WB pipeline register.
- Selects the writeback value per slot (memory read data or ALU result) and commits up to two writes per cycle into a 32x32-bit register file.
- Serves four combinational read ports to the decode stage (two per issue slot).
- Keeps a retired-write counter for performance and debug.

---
 rtl/wb_regfile_dual_pkg.sv | 18 +
 rtl/wb_regfile_dual_wb_select.sv | 15 +
 rtl/wb_regfile_dual.sv | 88 ++++++++
 3 files changed

// File: rtl/wb_regfile_dual_pkg.sv
// wb_regfile_dual_pkg: shared writeback widths, slot struct and register constants.
package wb_regfile_dual_pkg;

    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [XLEN-1:0]       readdata;
        logic [XLEN-1:0]       resultalu;
        logic [REG_ADDR_W-1:0] rd;
        logic                  memtoreg;
        logic                  regwrite;
    } wb_slot_t;

endpackage

// File: rtl/wb_regfile_dual_wb_select.sv
// wb_select: per-slot writeback mux and write-valid generation.
module wb_select
    import wb_regfile_dual_pkg::*;
(
    input  wb_slot_t        slot,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_valid
);

    always_comb begin
        wb_data  = slot.memtoreg ? slot.readdata : slot.resultalu;
        wb_valid = slot.regwrite && (slot.rd != REG_ZERO);
    end

endmodule

// File: rtl/wb_regfile_dual.sv
// wb_regfile_dual: dual-slot writeback into a 32x32 register file with four read ports.
// Optional same-cycle write-to-read bypass enabled by defining WB_REGFILE_BYPASS_EN.
module wb_regfile_dual
    import wb_regfile_dual_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [XLEN-1:0]       readdata_in_1,
    input  logic [XLEN-1:0]       resultalu_in_1,
    input  logic [REG_ADDR_W-1:0] rd_in_1,
    input  logic                  memtoreg_in1,
    input  logic                  regwrite_in1,
    input  logic [XLEN-1:0]       readdata_in_2,
    input  logic [XLEN-1:0]       resultalu_in_2,
    input  logic [REG_ADDR_W-1:0] rd_in_2,
    input  logic                  memtoreg_in2,
    input  logic                  regwrite_in2,
    input  logic [REG_ADDR_W-1:0] rs1_a,
    input  logic [REG_ADDR_W-1:0] rs2_a,
    input  logic [REG_ADDR_W-1:0] rs1_b,
    input  logic [REG_ADDR_W-1:0] rs2_b,
    output logic [XLEN-1:0]       rdata1_a,
    output logic [XLEN-1:0]       rdata2_a,
    output logic [XLEN-1:0]       rdata1_b,
    output logic [XLEN-1:0]       rdata2_b,
    output logic [XLEN-1:0]       wb_data_1,
    output logic [XLEN-1:0]       wb_data_2,
    output logic                  wb_valid_1,
    output logic                  wb_valid_2,
    output logic [CNT_W-1:0]      retired_cnt
);

    wb_slot_t              slot_1, slot_2;
    logic [XLEN-1:0]       regs_q [NREGS];
    logic [XLEN-1:0]       regs_d [NREGS];
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [REG_ADDR_W-1:0] raddr [4];
    logic [XLEN-1:0]       rdata [4];

    assign slot_1 = '{readdata: readdata_in_1, resultalu: resultalu_in_1, rd: rd_in_1,
                      memtoreg: memtoreg_in1, regwrite: regwrite_in1};
    assign slot_2 = '{readdata: readdata_in_2, resultalu: resultalu_in_2, rd: rd_in_2,
                      memtoreg: memtoreg_in2, regwrite: regwrite_in2};

    wb_select u_sel_1 (.slot(slot_1), .wb_data(wb_data_1), .wb_valid(wb_valid_1));
    wb_select u_sel_2 (.slot(slot_2), .wb_data(wb_data_2), .wb_valid(wb_valid_2));

    // Slot 2 is applied last so it overrides slot 1 on a same-rd collision.
    always_comb begin
        regs_d = regs_q;
        if (wb_valid_1) regs_d[rd_in_1] = wb_data_1;
        if (wb_valid_2) regs_d[rd_in_2] = wb_data_2;
        regs_d[REG_ZERO] = '0;
        cnt_d = cnt_q + CNT_W'(wb_valid_1) + CNT_W'(wb_valid_2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '{default: '0};
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
        end
    end

    assign raddr = '{rs1_a, rs2_a, rs1_b, rs2_b};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rdata[i] = regs_q[raddr[i]];
`ifdef WB_REGFILE_BYPASS_EN
            if (wb_valid_1 && rd_in_1 == raddr[i]) rdata[i] = wb_data_1;
            if (wb_valid_2 && rd_in_2 == raddr[i]) rdata[i] = wb_data_2;
`endif
            if (reset || raddr[i] == REG_ZERO) rdata[i] = '0;
        end
    end

    assign rdata1_a    = rdata[0];
    assign rdata2_a    = rdata[1];
    assign rdata1_b    = rdata[2];
    assign rdata2_b    = rdata[3];
    assign retired_cnt = cnt_q;

endmodule
